// File: rtl/operand_fetch_pkg.sv
// Shared types for the operand fetch stage.
package operand_fetch_pkg;
  localparam int XLEN     = 32;
  localparam int CTRL_W   = 64;
  localparam int NUM_REGS = 32;

  typedef logic [4:0]        reg_idx_t;
  typedef logic [XLEN-1:0]   word;
  typedef logic [CTRL_W-1:0] ctrl_t;

  typedef struct packed {
    word      rs1_val;
    word      rs2_val;
    reg_idx_t rd;
    logic     rd_w;
    ctrl_t    ctrl;
  } opfetch_bundle_t;

  // One-hot mask for a register index, all zeros when not enabled.
  function automatic logic [NUM_REGS-1:0] idx_mask(input logic en, input reg_idx_t idx);
    logic [NUM_REGS-1:0] one;
    one = {{(NUM_REGS-1){1'b0}}, 1'b1};
    return en ? (one << idx) : '0;
  endfunction
endpackage

// File: rtl/operand_fetch_if.sv
// Decode/execute/regfile/writeback signals around the operand fetch stage.
// master = environment side, slave = the stage itself.
interface operand_fetch_if
  import operand_fetch_pkg::*;
#(
  parameter int XLEN   = operand_fetch_pkg::XLEN,
  parameter int CTRL_W = operand_fetch_pkg::CTRL_W
);
  logic              in_valid;
  logic              in_ready;
  reg_idx_t          in_rs1, in_rs2;
  logic              in_use_rs1, in_use_rs2;
  reg_idx_t          in_rd;
  logic              in_rd_w;
  logic [CTRL_W-1:0] in_ctrl;
  reg_idx_t          rf_rs1_sel, rf_rs2_sel;
  logic [XLEN-1:0]   rf_rs1_data, rf_rs2_data;
  logic              ex_fwd_valid;
  reg_idx_t          ex_fwd_rd;
  logic [XLEN-1:0]   ex_fwd_data;
  logic              wb_valid;
  reg_idx_t          wb_rd;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_rs1_val, out_rs2_val;
  reg_idx_t          out_rd;
  logic              out_rd_w;
  logic [CTRL_W-1:0] out_ctrl;

  modport master (
    output in_valid, in_rs1, in_rs2, in_use_rs1, in_use_rs2, in_rd, in_rd_w, in_ctrl,
           rf_rs1_data, rf_rs2_data, ex_fwd_valid, ex_fwd_rd, ex_fwd_data,
           wb_valid, wb_rd, flush, out_ready,
    input  in_ready, rf_rs1_sel, rf_rs2_sel, out_valid, out_rs1_val, out_rs2_val,
           out_rd, out_rd_w, out_ctrl
  );

  modport slave (
    input  in_valid, in_rs1, in_rs2, in_use_rs1, in_use_rs2, in_rd, in_rd_w, in_ctrl,
           rf_rs1_data, rf_rs2_data, ex_fwd_valid, ex_fwd_rd, ex_fwd_data,
           wb_valid, wb_rd, flush, out_ready,
    output in_ready, rf_rs1_sel, rf_rs2_sel, out_valid, out_rs1_val, out_rs2_val,
           out_rd, out_rd_w, out_ctrl
  );
endinterface

// File: rtl/operand_fetch_reg_scoreboard.sv
// Pending-write bits per architectural register. The pending view already
// excludes a register being written back this cycle, since the regfile
// makes that value readable in the same cycle.
module reg_scoreboard
  import operand_fetch_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                set_en,
  input  reg_idx_t            set_idx,
  input  logic                clr_en,
  input  reg_idx_t            clr_idx,
  input  logic                flush_clr_en,
  input  reg_idx_t            flush_clr_idx,
  output logic [NUM_REGS-1:0] pending
);
  logic [NUM_REGS-1:0] sb_q;

  assign pending = sb_q & ~idx_mask(clr_en, clr_idx);

  // Clears first, then set: a new issue to a register whose writeback
  // lands this same cycle must remain pending.
  always_ff @(posedge clk) begin
    if (rst) sb_q <= '0;
    else begin
      sb_q    <= (sb_q & ~idx_mask(clr_en, clr_idx) & ~idx_mask(flush_clr_en, flush_clr_idx))
               | idx_mask(set_en, set_idx);
      sb_q[0] <= 1'b0;
    end
  end
endmodule

// File: rtl/operand_fetch.sv
// Operand fetch / issue stage: hazard check, execute-result forwarding and
// registered operand bundle towards execute.
// Optional feature: define OPFETCH_FWD_EN to enable execute-result forwarding;
// without it RAW hazards stall until the writeback cycle.
module operand_fetch
  import operand_fetch_pkg::*;
(
  input logic           clk,
  input logic           rst,
  operand_fetch_if.slave bus
);
  logic [NUM_REGS-1:0] pending;
  logic                fwd_hit1, fwd_hit2;
  logic                hazard, accept;
  word                 rs1_val, rs2_val;
  opfetch_bundle_t     out_q;

  assign bus.rf_rs1_sel = bus.in_rs1;
  assign bus.rf_rs2_sel = bus.in_rs2;

`ifdef OPFETCH_FWD_EN
  assign fwd_hit1 = bus.ex_fwd_valid && (bus.ex_fwd_rd == bus.in_rs1);
  assign fwd_hit2 = bus.ex_fwd_valid && (bus.ex_fwd_rd == bus.in_rs2);
`else
  logic unused_fwd;
  assign fwd_hit1   = 1'b0;
  assign fwd_hit2   = 1'b0;
  assign unused_fwd = ^{bus.ex_fwd_valid, bus.ex_fwd_rd, bus.ex_fwd_data};
`endif

  // RAW on either source (unless forwarded) or WAW on the destination.
  always_comb begin
    hazard = 1'b0;
    if (bus.in_use_rs1 && bus.in_rs1 != '0 && pending[bus.in_rs1] && !fwd_hit1) hazard = 1'b1;
    if (bus.in_use_rs2 && bus.in_rs2 != '0 && pending[bus.in_rs2] && !fwd_hit2) hazard = 1'b1;
    if (bus.in_rd_w && bus.in_rd != '0 && pending[bus.in_rd]) hazard = 1'b1;
  end

  assign bus.in_ready = !hazard && (!out_q_valid() || bus.out_ready) && !bus.flush;
  assign accept       = bus.in_valid && bus.in_ready;

  // Operand select: x0 reads as zero, then forwarded result, then regfile.
  always_comb begin
    rs1_val = bus.rf_rs1_data;
    rs2_val = bus.rf_rs2_data;
    if (fwd_hit1) rs1_val = bus.ex_fwd_data;
    if (fwd_hit2) rs2_val = bus.ex_fwd_data;
    if (bus.in_rs1 == '0) rs1_val = '0;
    if (bus.in_rs2 == '0) rs2_val = '0;
  end

  logic out_valid_q;
  function automatic logic out_q_valid();
    return out_valid_q;
  endfunction

  // Output register: flush drops the held bundle, otherwise load on accept
  // and release after the execute handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else if (bus.flush) begin
      out_valid_q <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_q       <= '{rs1_val: rs1_val, rs2_val: rs2_val, rd: bus.in_rd,
                       rd_w: bus.in_rd_w, ctrl: bus.in_ctrl};
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.out_rs1_val = out_q.rs1_val;
  assign bus.out_rs2_val = out_q.rs2_val;
  assign bus.out_rd      = out_q.rd;
  assign bus.out_rd_w    = out_q.rd_w;
  assign bus.out_ctrl    = out_q.ctrl;

  reg_scoreboard u_sb (
    .clk           (clk),
    .rst           (rst),
    .set_en        (accept && bus.in_rd_w && bus.in_rd != '0),
    .set_idx       (bus.in_rd),
    .clr_en        (bus.wb_valid),
    .clr_idx       (bus.wb_rd),
    .flush_clr_en  (bus.flush && out_valid_q && out_q.rd_w),
    .flush_clr_idx (out_q.rd),
    .pending       (pending)
  );
endmodule
